// File: rtl/cpu_core_mc.sv
// -----------------------------------------------------------------------------
// cpu_core_mc -- small multi-cycle 16-bit CPU core.
//
// Instructions take FETCH -> DECODE -> EXECUTE (3 cycles). LOAD adds a
// MEM_WAIT cycle (4 cycles). HALT parks the core in HALTED until reset.
// Instruction and data memories are external and synchronous: each read
// returns its data one cycle after the address is presented.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_run        run enable, sampled only in FETCH
//   o_inst_addr  instruction address (= PC)
//   i_inst       instruction word, valid the cycle after o_inst_addr
//   o_mem_addr   data address (k field of IR)
//   o_mem_wdata  store data (R[rd])
//   o_mem_we     store strobe, high only in EXECUTE of a STORE
//   i_mem_rdata  load data, valid the cycle after o_mem_addr
//   o_halted     high in HALTED
//   o_r0         live value of R0 (debug)
// -----------------------------------------------------------------------------
module cpu_core_mc #(
  parameter int INST_ADDR_WIDTH = 8,
  parameter int DATA_ADDR_WIDTH = 8,
  parameter int RESET_PC        = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_run,
  output logic [INST_ADDR_WIDTH-1:0] o_inst_addr,
  input  logic [15:0]                i_inst,
  output logic [DATA_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]                o_mem_wdata,
  output logic                       o_mem_we,
  input  logic [15:0]                i_mem_rdata,
  output logic                       o_halted,
  output logic [15:0]                o_r0
);

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM_WAIT, ST_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD   = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR    = 4'h3,
    OP_SHIFT = 4'h4, OP_LOAD = 4'h5, OP_STORE = 4'h6, OP_MOVE = 4'h7,
    OP_JUMP  = 4'h8, OP_LOADC = 4'h9, OP_HALT = 4'hF
  } op_e;

  state_e state, next_state;

  logic [INST_ADDR_WIDTH-1:0] pc, pc_next, pc_inc;
  logic [15:0]                ir;
  logic [15:0]                regs [4];

  // Instruction fields, decoded from the held IR.
  op_e        op;
  logic [1:0] rd, ext, rs;
  logic [7:0] k;
  logic [15:0] rd_val, operand_b;

  logic        ir_load;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic        jump_taken;

  assign op  = op_e'(ir[15:12]);
  assign rd  = ir[11:10];
  assign ext = ir[9:8];
  assign k   = ir[7:0];
  assign rs  = ir[1:0];

  assign rd_val    = regs[rd];
  assign operand_b = ext[1] ? {8'h00, k} : regs[rs];
  assign pc_inc    = pc + INST_ADDR_WIDTH'(1);

  // NOTE: every signal driven here gets a default first so no path through the
  // case statements leaves it unassigned, which would infer a latch.
  always_comb begin
    next_state = state;
    pc_next    = pc;
    ir_load    = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = rd_val;
    o_mem_we   = 1'b0;
    jump_taken = 1'b0;

    unique case (state)
      ST_FETCH: begin
        if (i_run) next_state = ST_DECODE;
      end

      ST_DECODE: begin
        ir_load    = 1'b1;
        next_state = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        next_state = ST_FETCH;
        pc_next    = pc_inc;
        case (op)
          OP_ADD:   begin reg_we = 1'b1; reg_wdata = rd_val + operand_b; end
          OP_SUB:   begin reg_we = 1'b1; reg_wdata = rd_val - operand_b; end
          OP_AND:   begin reg_we = 1'b1; reg_wdata = rd_val & operand_b; end
          OP_OR:    begin reg_we = 1'b1; reg_wdata = rd_val | operand_b; end
          OP_SHIFT: begin
            reg_we    = 1'b1;
            reg_wdata = ext[0] ? (rd_val >> operand_b[3:0])
                               : (rd_val << operand_b[3:0]);
          end
          OP_LOAD: begin
            // PC advances when the data is written back in MEM_WAIT.
            next_state = ST_MEM_WAIT;
            pc_next    = pc;
          end
          OP_STORE: o_mem_we = 1'b1;
          OP_MOVE:  begin reg_we = 1'b1; reg_wdata = regs[rs]; end
          OP_JUMP: begin
            case (ext)
              2'b00:   jump_taken = 1'b1;
              2'b01:   jump_taken = (rd_val == 16'h0000);
              2'b10:   jump_taken = (rd_val != 16'h0000);
              default: jump_taken = rd_val[15];
            endcase
            if (jump_taken) pc_next = INST_ADDR_WIDTH'(k);
          end
          OP_LOADC: begin
            reg_we    = 1'b1;
            reg_wdata = ext[0] ? {k, rd_val[7:0]} : {8'h00, k};
          end
          OP_HALT: begin
            next_state = ST_HALTED;
            pc_next    = pc;
          end
          default: ;  // ops A..E: no-op, PC still advances
        endcase
      end

      ST_MEM_WAIT: begin
        reg_we     = 1'b1;
        reg_wdata  = i_mem_rdata;
        pc_next    = pc_inc;
        next_state = ST_FETCH;
      end

      ST_HALTED: next_state = ST_HALTED;

      default: next_state = ST_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is also what makes operands read before the
  // same-cycle register write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_FETCH;
      pc    <= INST_ADDR_WIDTH'(RESET_PC);
      ir    <= 16'h0000;
    end else begin
      state <= next_state;
      pc    <= pc_next;
      if (ir_load) ir <= i_inst;
    end
  end

  // NOTE: the register file is only four words, and architecturally it must
  // read zero after reset, so it is reset like ordinary flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 16'h0000;
    end else if (reg_we) begin
      regs[rd] <= reg_wdata;
    end
  end

  assign o_inst_addr = pc;
  assign o_mem_addr  = k[DATA_ADDR_WIDTH-1:0];
  assign o_mem_wdata = rd_val;
  assign o_halted    = (state == ST_HALTED);
  assign o_r0        = regs[0];

endmodule

// File: tb/tb_cpu_core_mc.sv
// -----------------------------------------------------------------------------
// tb_cpu_core_mc -- directed self-checking bench for cpu_core_mc.
// Synchronous instruction ROM and data RAM models; a linear program of
// hand-encoded instructions with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_cpu_core_mc;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_run;
  logic [7:0]  o_inst_addr;
  logic [15:0] i_inst;
  logic [7:0]  o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_mem_we;
  logic [15:0] i_mem_rdata;
  logic        o_halted;
  logic [15:0] o_r0;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rom  [256];
  logic [15:0] dmem [256];

  cpu_core_mc #(
    .INST_ADDR_WIDTH(8),
    .DATA_ADDR_WIDTH(8),
    .RESET_PC(0)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (i_run),
    .o_inst_addr(o_inst_addr),
    .i_inst     (i_inst),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_mem_we   (o_mem_we),
    .i_mem_rdata(i_mem_rdata),
    .o_halted   (o_halted),
    .o_r0       (o_r0)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous memories: data is returned the cycle after the address.
  always @(posedge i_clk) begin
    i_inst      <= rom[o_inst_addr];
    i_mem_rdata <= dmem[o_mem_addr];
    if (o_mem_we) dmem[o_mem_addr] <= o_mem_wdata;
  end

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sample 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i]  = 16'hA000;  // no-op filler
      dmem[i] = 16'h0000;
    end
    rom[8'h00] = 16'h9405;  // LOADC R1,0x05
    rom[8'h01] = 16'h9803;  // LOADC R2,0x03
    rom[8'h02] = 16'h0402;  // ADD   R1,R2
    rom[8'h03] = 16'h7001;  // MOVE  R0,R1
    rom[8'h04] = 16'h9034;  // LOADC R0,0x34
    rom[8'h05] = 16'h9112;  // LOADC-high R0,0x12
    rom[8'h06] = 16'h4304;  // SHIFT right R0 by k=4
    rom[8'h07] = 16'h1224;  // SUB   R0,k=0x24
    rom[8'h08] = 16'h4002;  // SHIFT left R0 by R2 (3)
    rom[8'h09] = 16'h22F0;  // AND   R0,k=0xF0
    rom[8'h0A] = 16'h3001;  // OR    R0,R1 (8)
    rom[8'h0B] = 16'h90EF;  // LOADC R0,0xEF
    rom[8'h0C] = 16'h91BE;  // LOADC-high R0,0xBE
    rom[8'h0D] = 16'h6010;  // STORE R0 -> [0x10]
    rom[8'h0E] = 16'h5C10;  // LOAD  R3 <- [0x10]
    rom[8'h0F] = 16'h9000;  // LOADC R0,0x00
    rom[8'h10] = 16'h7003;  // MOVE  R0,R3
    rom[8'h11] = 16'h9400;  // LOADC R1,0x00
    rom[8'h12] = 16'h8540;  // JUMP  ext=01 (R1==0) -> 0x40
    rom[8'h20] = 16'hF000;  // HALT
    rom[8'h40] = 16'h8680;  // JUMP  ext=10 (R1!=0) -> 0x80, not taken
    rom[8'h41] = 16'h9580;  // LOADC-high R1,0x80 -> R1=0x8000
    rom[8'h42] = 16'h8750;  // JUMP  ext=11 (R1[15]) -> 0x50
    rom[8'h50] = 16'hA000;  // op A no-op
    rom[8'h51] = 16'h80FF;  // JUMP  always -> 0xFF
    rom[8'hFF] = 16'h0201;  // ADD   R0,k=1 ; PC wraps to 0x00

    i_rst_n = 1'b0;
    i_run   = 1'b0;
    #1;
    check("rst_halted", {15'd0, o_halted}, 16'h0000);
    check("rst_we",     {15'd0, o_mem_we}, 16'h0000);
    check("rst_pc",     {8'd0, o_inst_addr}, 16'h0000);
    check("rst_r0",     o_r0, 16'h0000);
    step(3);
    i_rst_n = 1'b1;
    i_run   = 1'b1;

    // LOADC/LOADC/ADD/MOVE: R0 only written on the 12th edge.
    step(11);
    check("r0_before_move", o_r0, 16'h0000);
    step(1);
    check("add_move_r0", o_r0, 16'h0008);
    check("pc_after_4",  {8'd0, o_inst_addr}, 16'h0004);

    step(3); check("loadc_lo",   o_r0, 16'h0034);
    step(3); check("loadc_hi",   o_r0, 16'h1234);
    step(3); check("shift_r_k",  o_r0, 16'h0123);
    step(3); check("sub_k",      o_r0, 16'h00FF);
    step(3); check("shift_l_rs", o_r0, 16'h07F8);
    step(3); check("and_k",      o_r0, 16'h00F0);
    step(3); check("or_rs",      o_r0, 16'h00F8);
    step(3); step(3); check("beef", o_r0, 16'hBEEF);

    // STORE: strobe only in EXECUTE.
    step(1);
    check("store_decode_we", {15'd0, o_mem_we}, 16'h0000);
    step(1);
    check("store_exec_we",   {15'd0, o_mem_we}, 16'h0001);
    check("store_addr",      {8'd0, o_mem_addr}, 16'h0010);
    check("store_wdata",     o_mem_wdata, 16'hBEEF);
    step(1);
    check("store_after_we",  {15'd0, o_mem_we}, 16'h0000);
    check("store_mem",       dmem[8'h10], 16'hBEEF);
    check("store_pc",        {8'd0, o_inst_addr}, 16'h000E);

    // LOAD: four cycles; PC held through MEM_WAIT.
    step(3); check("load_memwait_pc", {8'd0, o_inst_addr}, 16'h000E);
    step(1); check("load_done_pc",    {8'd0, o_inst_addr}, 16'h000F);
    step(3); step(3); check("load_r3_via_r0", o_r0, 16'hBEEF);

    // Jumps.
    step(3); step(3); check("jump_eq_taken",  {8'd0, o_inst_addr}, 16'h0040);
    step(3);          check("jump_ne_not",    {8'd0, o_inst_addr}, 16'h0041);
    step(3); step(3); check("jump_neg_taken", {8'd0, o_inst_addr}, 16'h0050);
    step(3);          check("noop_pc",        {8'd0, o_inst_addr}, 16'h0051);
    rom[8'h00] = 16'h8020;  // JUMP always -> 0x20 (HALT)
    step(3);          check("jump_always",    {8'd0, o_inst_addr}, 16'h00FF);
    step(3);
    check("pc_wrap", {8'd0, o_inst_addr}, 16'h0000);
    check("wrap_add_r0", o_r0, 16'hBEF0);

    // HALT.
    step(3); check("pc_to_halt", {8'd0, o_inst_addr}, 16'h0020);
    step(3);
    check("halted",      {15'd0, o_halted}, 16'h0001);
    check("halt_pc",     {8'd0, o_inst_addr}, 16'h0020);
    step(5);
    check("halted_stay", {15'd0, o_halted}, 16'h0001);
    check("halt_pc_const", {8'd0, o_inst_addr}, 16'h0020);

    // Asynchronous reset out of HALTED.
    i_rst_n = 1'b0;
    #1;
    check("rst_unhalt", {15'd0, o_halted}, 16'h0000);
    check("rst_pc2",    {8'd0, o_inst_addr}, 16'h0000);
    check("rst_r0_2",   o_r0, 16'h0000);
    step(2);

    // i_run=0 holds the core in FETCH.
    rom[8'h00] = 16'h5010;  // LOAD R0 <- [0x10]
    i_run   = 1'b0;
    i_rst_n = 1'b1;
    step(5);
    check("idle_pc",     {8'd0, o_inst_addr}, 16'h0000);
    check("idle_r0",     o_r0, 16'h0000);
    check("idle_halted", {15'd0, o_halted}, 16'h0000);
    check("idle_we",     {15'd0, o_mem_we}, 16'h0000);

    // Reset during MEM_WAIT aborts the load.
    i_run = 1'b1;
    step(3);
    check("abort_memwait_pc", {8'd0, o_inst_addr}, 16'h0000);
    i_rst_n = 1'b0;
    step(1);
    check("abort_load_r0", o_r0, 16'h0000);

    // Reset during STORE EXECUTE drops the strobe without a clock edge.
    rom[8'h00] = 16'h6C10;  // STORE R3 (0) -> [0x10]
    i_run   = 1'b0;
    i_rst_n = 1'b1;
    step(1);
    i_run = 1'b1;
    step(2);
    check("abort_store_we", {15'd0, o_mem_we}, 16'h0001);
    i_rst_n = 1'b0;
    #1;
    check("abort_store_we_drop", {15'd0, o_mem_we}, 16'h0000);
    step(1);
    check("abort_store_mem", dmem[8'h10], 16'hBEEF);
    check("abort_store_r0",  o_r0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
